// File: rtl/tile_ram_arbiter.sv
// Tile-RAM arbiter: VGA has absolute priority, game and ghost logic share
// the remaining slots round-robin, with a one-slot lock for game logic.
module tile_ram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_dout,
    output logic              vga_valid,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic              gl_lock,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [DATA_W-1:0] gl_din,
    output logic              gl_gnt,
    output logic [DATA_W-1:0] gl_dout,
    output logic              gl_valid,
    input  logic              gh_req,
    input  logic              gh_we,
    input  logic [ADDR_W-1:0] gh_addr,
    input  logic [DATA_W-1:0] gh_din,
    output logic              gh_gnt,
    output logic [DATA_W-1:0] gh_dout,
    output logic              gh_valid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VGA,
        OWN_GL,
        OWN_GH
    } own_e;

    own_e              win_d, tag_d, tag0_q, tag1_q;
    logic              ptr_q, ptr_d;
    logic              lock_q, lock_d;
    logic              gl_elig, gh_elig, we_d;
    logic              ram_en_q, ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_din_q;
    logic              gl_gnt_q, gh_gnt_q;
    logic              vga_valid_q, gl_valid_q, gh_valid_q;
    logic [DATA_W-1:0] vga_dout_q, gl_dout_q, gh_dout_q;

    // A requester is masked in its grant cycle: its req is still the old one.
    // While a lock is pending, gh may not steal gl's masked cycle.
    always_comb begin
        gl_elig = gl_req && !gl_gnt_q;
        gh_elig = gh_req && !gh_gnt_q && !(lock_q && gl_gnt_q);
        win_d   = OWN_NONE;
        ptr_d   = ptr_q;
        lock_d  = 1'b0;
        if (vga_req) begin
            win_d  = OWN_VGA;
            lock_d = lock_q && gl_req;
        end else if (gl_elig && (lock_q || !gh_elig || !ptr_q)) begin
            win_d  = OWN_GL;
            ptr_d  = 1'b1;
            lock_d = gl_lock;
        end else if (gh_elig) begin
            win_d  = OWN_GH;
            ptr_d  = 1'b0;
        end else begin
            lock_d = lock_q && gl_gnt_q;
        end
    end

    always_comb begin
        we_d  = 1'b0;
        tag_d = OWN_NONE;
        unique case (win_d)
            OWN_VGA: tag_d = OWN_VGA;
            OWN_GL: begin
                we_d  = gl_we;
                tag_d = gl_we ? OWN_NONE : OWN_GL;
            end
            OWN_GH: begin
                we_d  = gh_we;
                tag_d = gh_we ? OWN_NONE : OWN_GH;
            end
            OWN_NONE: tag_d = OWN_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            gl_gnt_q    <= 1'b0;
            gh_gnt_q    <= 1'b0;
            tag0_q      <= OWN_NONE;
            tag1_q      <= OWN_NONE;
            vga_valid_q <= 1'b0;
            gl_valid_q  <= 1'b0;
            gh_valid_q  <= 1'b0;
            vga_dout_q  <= '0;
            gl_dout_q   <= '0;
            gh_dout_q   <= '0;
            ptr_q       <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            ram_en_q <= (win_d != OWN_NONE);
            ram_we_q <= we_d;
            unique case (win_d)
                OWN_VGA: ram_addr_q <= vga_addr;
                OWN_GL: begin
                    ram_addr_q <= gl_addr;
                    ram_din_q  <= gl_din;
                end
                OWN_GH: begin
                    ram_addr_q <= gh_addr;
                    ram_din_q  <= gh_din;
                end
                OWN_NONE: ;
            endcase
            gl_gnt_q    <= (win_d == OWN_GL);
            gh_gnt_q    <= (win_d == OWN_GH);
            tag0_q      <= tag_d;
            tag1_q      <= tag0_q;
            vga_valid_q <= (tag1_q == OWN_VGA);
            gl_valid_q  <= (tag1_q == OWN_GL);
            gh_valid_q  <= (tag1_q == OWN_GH);
            if (tag1_q == OWN_VGA) vga_dout_q <= ram_dout;
            if (tag1_q == OWN_GL)  gl_dout_q  <= ram_dout;
            if (tag1_q == OWN_GH)  gh_dout_q  <= ram_dout;
            ptr_q  <= ptr_d;
            lock_q <= lock_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign gl_gnt    = gl_gnt_q;
    assign gh_gnt    = gh_gnt_q;
    assign vga_valid = vga_valid_q;
    assign gl_valid  = gl_valid_q;
    assign gh_valid  = gh_valid_q;
    assign vga_dout  = vga_dout_q;
    assign gl_dout   = gl_dout_q;
    assign gh_dout   = gh_dout_q;

endmodule
